// File: rtl/covariance_mat.sv
// Covariance stage of the fetal ECG ICA datapath.
// Computes C = (X * X^T) / SIZE_B with one time-shared MAC under an FSM.
module covariance_mat #(
  parameter int SIZE_A = 8,
  parameter int SIZE_B = 8,
  parameter int N_BITS = 35
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic signed [N_BITS-1:0]   mat [SIZE_A][SIZE_B],
  output logic                       busy,
  output logic                       done,
  output logic signed [2*N_BITS-1:0] cov [SIZE_A][SIZE_A]
);

  localparam int SH = $clog2(SIZE_B);
  localparam int PW = 2 * N_BITS;
  localparam int AW = PW + SH;
  localparam int IW = (SIZE_A > 1) ? $clog2(SIZE_A) : 1;
  localparam int KW = SH;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    WRITE,
    DONE
  } state_t;

  state_t state_q;
  state_t state_d;

  logic signed [N_BITS-1:0] x [SIZE_A][SIZE_B];
  logic signed [AW-1:0]     acc;
  logic [IW-1:0]            i;
  logic [IW-1:0]            j;
  logic [KW-1:0]            k;

  logic signed [N_BITS-1:0] xa;
  logic signed [N_BITS-1:0] xb;
  logic signed [PW-1:0]     prod;
  logic signed [AW-1:0]     sum;
  logic signed [PW-1:0]     r;
  logic                     accept;
  logic                     last_k;
  logic                     last_j;
  logic                     last_pair;

  assign accept    = (state_q == IDLE) && start;
  assign last_k    = (k == KW'(SIZE_B - 1));
  assign last_j    = (j == IW'(SIZE_A - 1));
  assign last_pair = last_j && (i == IW'(SIZE_A - 1));

  assign xa   = x[i][k];
  assign xb   = x[j][k];
  assign prod = PW'(xa) * PW'(xb);
  assign sum  = acc + AW'(prod);
  // Top PW bits of the accumulator are exactly floor(acc / SIZE_B).
  assign r    = acc[AW-1:SH];

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and status decode.
  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = MAC;
      end
      MAC: begin
        busy = 1'b1;
        if (last_k) state_d = WRITE;
      end
      WRITE: begin
        busy    = 1'b1;
        state_d = last_pair ? DONE : MAC;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Snapshot of the input matrix; mat is free to change afterwards.
  always_ff @(posedge clk) begin
    if (accept) begin
      x <= mat;
    end
  end

  // MAC datapath, pair walk and mirrored result write-back.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
      i   <= '0;
      j   <= '0;
      k   <= '0;
      for (int a = 0; a < SIZE_A; a++) begin
        for (int b = 0; b < SIZE_A; b++) begin
          cov[a][b] <= '0;
        end
      end
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            acc <= '0;
            i   <= '0;
            j   <= '0;
            k   <= '0;
          end
        end
        MAC: begin
          acc <= sum;
          k   <= k + KW'(1);
        end
        WRITE: begin
          cov[i][j] <= r;
          cov[j][i] <= r;
          acc       <= '0;
          k         <= '0;
          if (last_j) begin
            i <= i + IW'(1);
            j <= i + IW'(1);
          end else begin
            j <= j + IW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_covariance_mat.sv
// Self-checking bench for covariance_mat.
// Table vectors, model-checked random matrices and control sequences.
module tb_covariance_mat;

  localparam int A  = 8;
  localparam int B  = 8;
  localparam int NB = 35;
  localparam int CW = 2 * NB;

  typedef logic [A-1:0][A-1:0][CW-1:0] cmat_t;

  typedef struct packed {
    logic [B-1:0][NB-1:0] row0;
    logic [B-1:0][NB-1:0] row1;
    logic [NB-1:0]        fill;
    logic [CW-1:0]        c00;
    logic [CW-1:0]        c01;
    logic [CW-1:0]        c11;
    logic [CW-1:0]        crest;
  } vec_t;

  logic                 clk;
  logic                 rst;
  logic                 start;
  logic signed [NB-1:0] mat [A][B];
  logic                 busy;
  logic                 done;
  logic signed [CW-1:0] cov [A][A];

  int    checks;
  int    failures;
  cmat_t sb[$];
  vec_t  tbl[5];

  covariance_mat #(
    .SIZE_A(A),
    .SIZE_B(B),
    .N_BITS(NB)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .mat  (mat),
    .busy (busy),
    .done (done),
    .cov  (cov)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input bit ok, input string nm,
                     input logic [CW-1:0] act,
                     input logic [CW-1:0] req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  function automatic cmat_t exp_tbl(input vec_t v);
    cmat_t e;
    for (int r = 0; r < A; r++) begin
      for (int c = 0; c < A; c++) begin
        if (r == 0 && c == 0) e[r][c] = v.c00;
        else if (r == 1 && c == 1) e[r][c] = v.c11;
        else if ((r == 0 && c == 1) || (r == 1 && c == 0)) e[r][c] = v.c01;
        else e[r][c] = v.crest;
      end
    end
    return e;
  endfunction

  task automatic set_mat(input vec_t v);
    for (int r = 0; r < A; r++) begin
      for (int c = 0; c < B; c++) begin
        if (r == 0) mat[r][c] = v.row0[c];
        else if (r == 1) mat[r][c] = v.row1[c];
        else mat[r][c] = v.fill;
      end
    end
  endtask

  task automatic rand_mat();
    logic [63:0] rv;
    for (int r = 0; r < A; r++) begin
      for (int c = 0; c < B; c++) begin
        rv = {$urandom, $urandom};
        mat[r][c] = rv[NB-1:0];
      end
    end
  endtask

  // Reference: exact sum, then floor division by B.
  function automatic cmat_t model();
    cmat_t e;
    logic signed [79:0] s, a, b, q;
    for (int r = 0; r < A; r++) begin
      for (int c = 0; c < A; c++) begin
        s = '0;
        for (int n = 0; n < B; n++) begin
          a = 80'(mat[r][n]);
          b = 80'(mat[c][n]);
          s = s + a * b;
        end
        q = s / 80'sd8;
        if (s < 0 && (s % 80'sd8) != 0) q = q - 80'sd1;
        e[r][c] = q[CW-1:0];
      end
    end
    return e;
  endfunction

  task automatic check_sb();
    cmat_t e;
    if (sb.size() == 0) begin
      chk(1'b0, "sb_empty_on_done", 1, 0);
    end else begin
      e = sb.pop_front();
      for (int r = 0; r < A; r++) begin
        for (int c = 0; c < A; c++) begin
          chk(cov[r][c] === e[r][c], $sformatf("cov[%0d][%0d]", r, c),
              cov[r][c], e[r][c]);
        end
      end
    end
  endtask

  task automatic launch(input cmat_t e, input bit scramble);
    start = 1'b1;
    sb.push_back(e);
    @(posedge clk);
    #1;
    start = 1'b0;
    if (scramble) rand_mat();
  endtask

  // Called at cycle 1 after the accepting edge; watches busy/done.
  task automatic monitor(input int pulse_at, input int rst_at,
                         input int hold_from, input int limit,
                         input int exp_dones);
    int  cyc;
    int  dcyc;
    int  nd;
    int  bad;
    int  first_bad;
    bit  ebusy;
    cyc = 1;
    dcyc = -1;
    nd = 0;
    bad = 0;
    first_bad = -1;
    while (cyc <= limit) begin
      start = (cyc == pulse_at) || (hold_from > 0 && cyc >= hold_from);
      rst = (rst_at > 0 && cyc == rst_at);
      ebusy = (cyc <= 324) && !(rst_at > 0 && cyc > rst_at);
      if (busy !== ebusy) begin
        bad++;
        if (first_bad < 0) first_bad = cyc;
      end
      if (done === 1'b1) begin
        nd++;
        if (dcyc < 0) dcyc = cyc;
        check_sb();
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    if (hold_from == 0) start = 1'b0;
    rst = 1'b0;
    chk(bad == 0, $sformatf("busy_window(first_bad_cycle=%0d)", first_bad),
        bad, 0);
    chk(nd == exp_dones, "done_count", nd, exp_dones);
    if (exp_dones > 0) chk(dcyc == 325, "done_cycle", dcyc, 325);
  endtask

  task automatic check_cov_zero(input string nm);
    int nz;
    nz = 0;
    for (int r = 0; r < A; r++) begin
      for (int c = 0; c < A; c++) begin
        if (cov[r][c] !== '0) nz++;
      end
    end
    chk(nz == 0, nm, nz, 0);
  endtask

  initial begin
    cmat_t e;
    checks = 0;
    failures = 0;
    start = 1'b0;
    rst = 1'b1;
    for (int r = 0; r < A; r++)
      for (int c = 0; c < B; c++)
        mat[r][c] = '0;

    for (int t = 0; t < 5; t++) tbl[t] = '0;
    for (int n = 0; n < B; n++) begin
      tbl[1].row0[n] = (n % 2 == 0) ? 35'd1 : {NB{1'b1}};
      tbl[2].row0[n] = 35'd3;
      tbl[2].row1[n] = -35'sd2;
      tbl[4].row0[n] = {1'b1, 34'b0};
      tbl[4].row1[n] = {1'b1, 34'b0};
    end
    tbl[1].c00 = 70'd1;
    tbl[2].c00 = 70'd9;
    tbl[2].c11 = 70'd4;
    tbl[2].c01 = -70'sd6;
    tbl[3].row0[0] = 35'd1;
    tbl[3].row1[0] = {NB{1'b1}};
    tbl[3].c01 = -70'sd1;
    tbl[4].fill = {1'b1, 34'b0};
    tbl[4].c00 = 70'd1 << 68;
    tbl[4].c01 = 70'd1 << 68;
    tbl[4].c11 = 70'd1 << 68;
    tbl[4].crest = 70'd1 << 68;

    repeat (2) @(posedge clk);
    #1;
    chk(busy === 1'b0, "reset_busy", busy, 0);
    chk(done === 1'b0, "reset_done", done, 0);
    check_cov_zero("reset_cov_nonzero");
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int t = 0; t < 5; t++) begin
      set_mat(tbl[t]);
      launch(exp_tbl(tbl[t]), 1'b1);
      monitor(0, 0, 0, 330, 1);
    end

    for (int t = 0; t < 2; t++) begin
      rand_mat();
      e = model();
      launch(e, 1'b1);
      monitor(0, 0, 0, 330, 1);
    end

    set_mat(tbl[4]);
    launch(exp_tbl(tbl[4]), 1'b1);
    monitor(50, 0, 0, 330, 1);

    set_mat(tbl[2]);
    e = exp_tbl(tbl[2]);
    launch(e, 1'b0);
    monitor(0, 0, 320, 326, 1);
    chk(busy === 1'b1, "back_to_back_busy", busy, 1);
    start = 1'b0;
    sb.push_back(e);
    monitor(0, 0, 0, 330, 1);

    set_mat(tbl[4]);
    launch(exp_tbl(tbl[4]), 1'b1);
    monitor(0, 100, 0, 400, 0);
    chk(sb.size() == 1, "aborted_run_pending", sb.size(), 1);
    sb.delete();
    check_cov_zero("abort_cov_nonzero");

    set_mat(tbl[2]);
    launch(exp_tbl(tbl[2]), 1'b1);
    monitor(0, 0, 0, 330, 1);

    chk(sb.size() == 0, "sb_leftover", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
